alu_adder_arbiter: RTL and testbench

Shares one combinational 64-bit signed adder (existing module bitadder: a, b -> y) between NREQ requesters issuing add/sub operations. It arbitrates round-robin, latches the winning operands, and performs subtraction by two's-complement negation of b in front of the adder. It registers result, overflow flag and requester id, then holds them under a valid/ready response handshake. It sits between the ALU issue logic and the adder datapath.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_adder_arbiter_if.sv | 37 +++
 rtl/bitadder.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/alu_adder_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_adder_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op encodings, arbiter FSM states
// and a helper that sizes requester-id fields.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Id width for n requesters: clog2(n), never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_adder_arbiter_if.sv
// Request/response bundle between the ALU issue logic (master) and the
// shared-adder arbiter (slave).
//   req_valid/req_ready : per-requester handshake, ready is one-hot or zero
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              : per-requester op, 0 = add, 1 = sub (a - b)
//   rsp_valid/rsp_ready : single result handshake
//   rsp_y/rsp_ovf/rsp_id: result, signed overflow flag, issuing requester
interface alu_adder_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ALU_WIDTH,
  parameter int IDW   = id_width(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic                  rsp_ovf;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_ovf, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_ovf, rsp_id
  );

endinterface

// File: rtl/bitadder.sv
// Existing combinational 64-bit adder; sum wraps modulo 2^64.
//   a, b : operands
//   y    : a + b
module bitadder
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic [ALU_WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1, wrapping modulo N.
//   req   : request vector
//   last  : index granted most recently
//   grant : chosen index (0 when nothing is requested)
//   found : at least one request is set
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] grant,
  output logic           found
);

  logic [IDW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path
    // leaves one unassigned, which would otherwise infer a latch.
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_adder_arbiter.sv
// Shares one 64-bit adder between NREQ add/sub requesters. A round-robin
// grant latches the winner's operands (IDLE), the adder result and signed
// overflow are registered one cycle later (CALC), and the response is held
// until the consumer takes it (RESP). One op in flight, no overlap.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_adder_arbiter_if
module alu_adder_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ALU_WIDTH,
  parameter int IDW   = id_width(NREQ)
) (
  input logic                clk,
  input logic                rst,
  alu_adder_arbiter_if.slave bus
);

  state_t           state;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_ovf_q;
  logic [IDW-1:0]   rsp_id_q;

  logic [IDW-1:0]   grant;
  logic             found;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sa, sb, sy, ovf;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant),
    .found (found)
  );

  assign sel_a  = bus.req_a[int'(grant)*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[int'(grant)*WIDTH +: WIDTH];
  assign sel_op = bus.req_op[grant];

  assign bus.req_ready = (state == S_IDLE && found) ? (NREQ'(1) << grant) : '0;

  // Subtraction negates b in front of the adder. For the most negative b
  // the negation wraps to b itself; the overflow rule below still uses the
  // original sign of b, so 0 - MIN is correctly flagged.
  assign b_eff = (op_q == OP_SUB) ? (~b_q + WIDTH'(1)) : b_q;

  bitadder u_add (
    .a (a_q),
    .b (b_eff),
    .y (sum)
  );

  assign sa  = a_q[WIDTH-1];
  assign sb  = b_q[WIDTH-1];
  assign sy  = sum[WIDTH-1];
  assign ovf = (op_q == OP_SUB) ? ((sa != sb) && (sy != sa))
                                : ((sa == sb) && (sy != sa));

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      // NOTE: operand registers are cleared on reset as well, so an op
      // dropped by reset leaves no stale operands behind.
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            id_q   <= grant;
            last_q <= grant;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          rsp_y_q     <= sum;
          rsp_ovf_q   <= ovf;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Bench for alu_adder_arbiter: directed cases, stall, async reset, fairness
// and a random phase. Expected responses are queued at accept time from a
// 65-bit arithmetic model; a separate monitor pops and compares them.
module tb_alu_adder_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 64;
  localparam int IDW  = 1;

  localparam int M_OFF  = 0;
  localparam int M_RAND = 1;
  localparam int M_CONT = 2;

  typedef struct {
    logic [63:0] y;
    logic        ovf;
    int          id;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) bus ();

  alu_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  int          grant_log[$];
  logic [63:0] pa[NREQ];
  logic [63:0] pb[NREQ];
  logic        pop[NREQ];
  bit          pend[NREQ];
  logic [NREQ-1:0] fire;
  bit          busy;
  int          model_last;
  int          mode;
  int          rsp_policy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference: exact result in 65 bits; overflow when it does not fit 64.
  function automatic exp_t model_op(input logic [63:0] a, input logic [63:0] b,
                                    input logic op, input int id, input int acc);
    exp_t e;
    logic signed [64:0] xa, xb, t;
    xa = {a[63], a};
    xb = {b[63], b};
    t  = (op == OP_SUB) ? (xa - xb) : (xa + xb);
    e.y   = t[63:0];
    e.ovf = (t[64] != t[63]);
    e.id  = id;
    e.acc = acc;
    return e;
  endfunction

  function automatic int rr_next(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (bit_at(v, (last + k) % NREQ)) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic new_op(input int i);
    pa[i]   = rand_operand();
    pb[i]   = rand_operand();
    pop[i]  = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
    pend[i] = 1'b1;
  endtask

  task automatic drive();
    logic [NREQ-1:0]   v, o;
    logic [NREQ*W-1:0] av, bv;
    v = '0; o = '0; av = '0; bv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) v = v | (NREQ'(1) << i);
      if (pop[i])  o = o | (NREQ'(1) << i);
      av[i*W +: W] = pa[i];
      bv[i*W +: W] = pb[i];
    end
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_a     = av;
    bus.req_b     = bv;
  endtask

  // One clock: update requesters at the falling edge, then predict the
  // grant and queue the expected response for the coming rising edge.
  task automatic cycle();
    exp_t e;
    logic [NREQ-1:0] exp_rdy;
    int g;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (bit_at(fire, i)) pend[i] = 1'b0;
      if (!pend[i] && (mode == M_CONT || (mode == M_RAND && $urandom_range(0, 2) == 0)))
        new_op(i);
      else if (pend[i] && mode == M_RAND && $urandom_range(0, 15) == 0)
        pend[i] = 1'b0;
    end
    case (rsp_policy)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = ($urandom_range(0, 1) == 1);
    endcase
    drive();
    #1;
    fire = bus.req_valid & bus.req_ready;
    if (!rst) begin
      g = busy ? -1 : rr_next(bus.req_valid, model_last);
      exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      if (busy && bus.rsp_valid && bus.rsp_ready) busy = 1'b0;
      if (g >= 0) begin
        e = model_op(pa[g], pb[g], pop[g], g, cyc);
        exp_q.push_back(e);
        grant_log.push_back(g);
        model_last = g;
        busy = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_rsp_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input int i, input logic op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ey, input logic eovf);
    int n = 0;
    pa[i] = a; pb[i] = b; pop[i] = op; pend[i] = 1'b1;
    do begin
      cycle();
      n++;
    end while (!bit_at(fire, i) && n < 20);
    check({tag, "_accept"}, 64'(bit_at(fire, i)), 64'd1);
    wait_idle(tag);
    cycle();
    check({tag, "_y"},     bus.rsp_y, ey);
    check({tag, "_ovf"},   64'(bus.rsp_ovf), 64'(eovf));
    check({tag, "_id"},    64'(bus.rsp_id), 64'(i));
    check({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    grant_log.delete();
    busy       = 1'b0;
    model_last = NREQ - 1;
    fire       = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
  endtask

  // Monitor: compares each presented response once against the queue.
  initial begin
    exp_t e;
    bit shown;
    shown = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        shown = 1'b0;
      end else begin
        if (bus.rsp_valid && !shown) begin
          shown = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected no response", bus.rsp_id);
          end else begin
            e = exp_q.pop_front();
            check("rsp_y",       bus.rsp_y, e.y);
            check("rsp_ovf",     64'(bus.rsp_ovf), 64'(e.ovf));
            check("rsp_id",      64'(bus.rsp_id), 64'(e.id));
            check("rsp_latency", 64'(cyc - e.acc), 64'd2);
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) shown = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout: got no finish expected finish before 400000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    mode = M_OFF;
    rsp_policy = 1;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = OP_ADD;
    end
    bus.rsp_ready = 1'b0;
    flush_model();

    // Reset state.
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_y",     bus.rsp_y, 64'd0);
    check("reset_ovf",   64'(bus.rsp_ovf), 64'd0);
    check("reset_id",    64'(bus.rsp_id), 64'd0);
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #4 rst = 1'b0;

    // Directed arithmetic.
    run_op("add_small", 0, OP_ADD, 64'd1029, 64'd1027, 64'd2056, 1'b0);
    run_op("sub_neg",   1, OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("add_ovf",   1, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("sub_min",   0, OP_SUB, 64'd0, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("add_mid",   1, OP_ADD, 64'h5D9F, 64'hF0CB2, 64'd1010257, 1'b0);

    // Response stall: result held, no grant while blocked.
    rsp_policy = 0;
    pa[0] = 64'hFFFF_FFFF_FFFF_FFFD; pb[0] = 64'd10; pop[0] = OP_ADD; pend[0] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!bit_at(fire, 0) && n < 20);
    check("stall_accept", 64'(bit_at(fire, 0)), 64'd1);
    n = 0;
    do begin cycle(); n++; end while (!bus.rsp_valid && n < 10);
    pa[1] = 64'd100; pb[1] = 64'd1; pop[1] = OP_SUB; pend[1] = 1'b1;
    repeat (5) begin
      cycle();
      check("stall_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_y",     bus.rsp_y, 64'd7);
      check("stall_ovf",   64'(bus.rsp_ovf), 64'd0);
      check("stall_id",    64'(bus.rsp_id), 64'd0);
      check("stall_ready", 64'(bus.req_ready), 64'd0);
    end
    rsp_policy = 1;
    cycle();
    check("stall_release_busy", 64'(busy), 64'd0);
    cycle();
    check("stall_regrant", 64'(bit_at(fire, 1)), 64'd1);
    wait_idle("stall_next");
    cycle();
    check("stall_next_y",  bus.rsp_y, 64'd99);
    check("stall_next_id", 64'(bus.rsp_id), 64'd1);

    // Async reset while the op is in CALC: op dropped, outputs cleared.
    pa[1] = 64'd40; pb[1] = 64'd2; pop[1] = OP_ADD; pend[1] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!bit_at(fire, 1) && n < 20);
    check("rst_accept", 64'(bit_at(fire, 1)), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_y",     bus.rsp_y, 64'd0);
    check("rst_ovf",   64'(bus.rsp_ovf), 64'd0);
    check("rst_id",    64'(bus.rsp_id), 64'd0);
    flush_model();
    @(negedge clk);
    @(negedge clk);
    #4 rst = 1'b0;
    repeat (4) begin
      cycle();
      check("rst_dropped", 64'(bus.rsp_valid), 64'd0);
    end

    // Fairness with both requesters continuously valid.
    mode = M_CONT;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin
      cycle();
      n++;
    end
    check("rr_count", 64'(grant_log.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("rr_order", 64'(grant_log[k]), 64'(k % 2));

    // Random traffic with random consumer back-pressure.
    mode = M_RAND;
    rsp_policy = 2;
    repeat (800) cycle();

    // Drain.
    mode = M_OFF;
    rsp_policy = 1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    wait_idle("drain");
    cycle();
    cycle();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
